glitch_sweep: RTL and testbench

Autonomous sweep sequencer for the glitch generator. It walks a 2-D grid of glitch width × delay points and fires the glitch core a configured number of times per point. It waits for the core's ready handshake, inserts a target-recovery cooldown, counts target faults, and reports one result per grid point. It sits beside the glitch wishbone slave: it drives the width/delay/enable inputs of the glitch core in place of host register writes.

---
 rtl/glitch_sweep_pkg.sv | 21 ++
 rtl/glitch_sweep_if.sv | 16 +
 rtl/glitch_sweep_step.sv | 24 ++
 rtl/glitch_sweep.sv | 188 ++++++++++++++++++
 tb/tb_glitch_sweep.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/glitch_sweep_pkg.sv
// Shared definitions for the glitch sweep sequencer: state names and defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package glitch_sweep_pkg;

  typedef enum logic [3:0] {
    SWEEP_IDLE,
    SWEEP_LOAD,
    SWEEP_ARM,
    SWEEP_WAIT_ACK,
    SWEEP_WAIT_DONE,
    SWEEP_COOL,
    SWEEP_POINT,
    SWEEP_ADVANCE,
    SWEEP_FINISH
  } sweep_state_t;

  // Cycles allowed between the fire pulse and the core dropping ready.
  localparam int SWEEP_ACK_TIMEOUT_DEF = 16;

endpackage

// File: rtl/glitch_sweep_if.sv
// Glitch-core control bundle: width/delay setpoints, fire pulse, core ready.
// Latency: n/a (wiring only).
// Backpressure: core holds glitch_ready low while a glitch is in flight.
// Ports: width, delay, glitch_en (sequencer -> core); glitch_ready (core -> sequencer).
interface glitch_sweep_if #(
  parameter int WIDTH_W = 8,
  parameter int DELAY_W = 16
);
  logic [WIDTH_W-1:0] width;
  logic [DELAY_W-1:0] delay;
  logic               glitch_en;
  logic               glitch_ready;

  modport master (output width, delay, glitch_en, input glitch_ready);
  modport slave  (input width, delay, glitch_en, output glitch_ready);
endinterface

// File: rtl/glitch_sweep_step.sv
// Next grid coordinate along one axis, wrapping back to the first value.
// Latency: combinational.
// Backpressure: none.
// Ports: cur/first/last/step in; nxt (next or first) and wrap out.
module glitch_sweep_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] first,
  input  logic [W-1:0] last,
  input  logic [W-1:0] step,
  output logic [W-1:0] nxt,
  output logic         wrap
);
  // One extra bit so a step past the top of the field is seen as a wrap
  // instead of silently folding back to a small value.
  logic [W:0] sum;

  always_comb begin
    sum  = {1'b0, cur} + {1'b0, step};
    wrap = (step == '0) || sum[W] || (sum[W-1:0] > last);
    nxt  = wrap ? first : sum[W-1:0];
  end
endmodule

// File: rtl/glitch_sweep.sv
// Sweep sequencer: walks width x delay grid, fires the glitch core reps times per point.
// Latency: first fire pulse 2 cycles after start_i (no trigger); done_o 1 cycle after abort.
// Backpressure: each shot waits on glitch_ready (and trigger edge if enabled); no input stall.
// Ports: clk_i/rst_ni; start/abort/trigger controls; range, reps and cooldown config;
//        core bundle (master); fault_i; busy/done/err status; point_valid_o + fault_cnt_o.
module glitch_sweep
  import glitch_sweep_pkg::*;
#(
  parameter int WIDTH_W     = 8,
  parameter int DELAY_W     = 16,
  parameter int ACK_TIMEOUT = SWEEP_ACK_TIMEOUT_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               use_trig_i,
  input  logic               trig_i,
  input  logic [WIDTH_W-1:0] w_start_i,
  input  logic [WIDTH_W-1:0] w_end_i,
  input  logic [WIDTH_W-1:0] w_step_i,
  input  logic [DELAY_W-1:0] d_start_i,
  input  logic [DELAY_W-1:0] d_end_i,
  input  logic [DELAY_W-1:0] d_step_i,
  input  logic [7:0]         reps_i,
  input  logic [15:0]        cooldown_i,
  input  logic               fault_i,
  glitch_sweep_if.master     core,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               point_valid_o,
  output logic [7:0]         fault_cnt_o
);
  localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);

  sweep_state_t       state;
  logic [WIDTH_W-1:0] width_q, w_start_c, w_end_c, w_step_c, w_nxt;
  logic [DELAY_W-1:0] delay_q, d_start_c, d_end_c, d_step_c, d_nxt;
  logic               w_wrap, d_wrap;
  logic [7:0]         reps_c, rep_q, fcnt_q;
  logic [15:0]        cool_c, cool_cnt, ack_cnt;
  logic               en_q, shot_flt;
  logic               trig_s1, trig_s2, trig_s3;
  logic               trig_rise;

  assign core.width     = width_q;
  assign core.delay     = delay_q;
  assign core.glitch_en = en_q;
  assign trig_rise      = trig_s2 & ~trig_s3;

  glitch_sweep_step #(.W(WIDTH_W)) u_wstep (
    .cur(width_q), .first(w_start_c), .last(w_end_c), .step(w_step_c),
    .nxt(w_nxt), .wrap(w_wrap)
  );

  glitch_sweep_step #(.W(DELAY_W)) u_dstep (
    .cur(delay_q), .first(d_start_c), .last(d_end_c), .step(d_step_c),
    .nxt(d_nxt), .wrap(d_wrap)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= SWEEP_IDLE;
      width_q       <= '0;
      delay_q       <= '0;
      w_start_c     <= '0;
      w_end_c       <= '0;
      w_step_c      <= '0;
      d_start_c     <= '0;
      d_end_c       <= '0;
      d_step_c      <= '0;
      reps_c        <= '0;
      cool_c        <= '0;
      rep_q         <= '0;
      fcnt_q        <= '0;
      cool_cnt      <= '0;
      ack_cnt       <= '0;
      shot_flt      <= 1'b0;
      en_q          <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      point_valid_o <= 1'b0;
      fault_cnt_o   <= '0;
      trig_s1       <= 1'b0;
      trig_s2       <= 1'b0;
      trig_s3       <= 1'b0;
    end else begin
      trig_s1       <= trig_i;
      trig_s2       <= trig_s1;
      trig_s3       <= trig_s2;
      en_q          <= 1'b0;
      done_o        <= 1'b0;
      point_valid_o <= 1'b0;

      // done_o is raised on the way into FINISH so an abort shows up one
      // cycle later; busy_o then drops when FINISH retires.
      if (abort_i && state != SWEEP_IDLE && state != SWEEP_FINISH) begin
        done_o <= 1'b1;
        state  <= SWEEP_FINISH;
      end else begin
        case (state)
          SWEEP_IDLE: begin
            if (start_i && !abort_i) begin
              w_start_c <= w_start_i;
              w_end_c   <= w_end_i;
              w_step_c  <= w_step_i;
              d_start_c <= d_start_i;
              d_end_c   <= d_end_i;
              d_step_c  <= d_step_i;
              reps_c    <= (reps_i == 8'd0) ? 8'd1 : reps_i;
              cool_c    <= cooldown_i;
              err_o     <= 1'b0;
              busy_o    <= 1'b1;
              state     <= SWEEP_LOAD;
            end
          end
          SWEEP_LOAD: begin
            width_q <= w_start_c;
            delay_q <= d_start_c;
            rep_q   <= '0;
            fcnt_q  <= '0;
            state   <= SWEEP_ARM;
          end
          SWEEP_ARM: begin
            if (core.glitch_ready && (!use_trig_i || trig_rise)) begin
              en_q    <= 1'b1;
              ack_cnt <= '0;
              state   <= SWEEP_WAIT_ACK;
            end
          end
          SWEEP_WAIT_ACK: begin
            if (!core.glitch_ready) begin
              state <= SWEEP_WAIT_DONE;
            end else if (ack_cnt == ACK_LAST) begin
              err_o  <= 1'b1;
              done_o <= 1'b1;
              state  <= SWEEP_FINISH;
            end else begin
              ack_cnt <= ack_cnt + 16'd1;
            end
          end
          SWEEP_WAIT_DONE: begin
            if (core.glitch_ready) begin
              cool_cnt <= cool_c;
              shot_flt <= 1'b0;
              state    <= SWEEP_COOL;
            end
          end
          SWEEP_COOL: begin
            if (cool_cnt == 16'd0) begin
              // Fault on the exit cycle still belongs to this shot.
              if ((shot_flt || fault_i) && fcnt_q != 8'hFF) fcnt_q <= fcnt_q + 8'd1;
              rep_q <= rep_q + 8'd1;
              state <= (rep_q + 8'd1 < reps_c) ? SWEEP_ARM : SWEEP_POINT;
            end else begin
              shot_flt <= shot_flt | fault_i;
              cool_cnt <= cool_cnt - 16'd1;
            end
          end
          SWEEP_POINT: begin
            point_valid_o <= 1'b1;
            fault_cnt_o   <= fcnt_q;
            fcnt_q        <= '0;
            state         <= SWEEP_ADVANCE;
          end
          SWEEP_ADVANCE: begin
            if (d_wrap && w_wrap) begin
              done_o <= 1'b1;
              state  <= SWEEP_FINISH;
            end else begin
              delay_q <= d_nxt;
              if (d_wrap) width_q <= w_nxt;
              rep_q   <= '0;
              state   <= SWEEP_ARM;
            end
          end
          SWEEP_FINISH: begin
            busy_o <= 1'b0;
            state  <= SWEEP_IDLE;
          end
          default: state <= SWEEP_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_glitch_sweep.sv
// Bench for glitch_sweep: random and directed sweeps against a grid/shot reference model.
// Latency: n/a.
// Backpressure: a behavioural glitch core holds ready low for a fixed time per shot.
module tb_glitch_sweep;
  import glitch_sweep_pkg::*;

  localparam int WW        = 8;
  localparam int DW        = 16;
  localparam int AT        = SWEEP_ACK_TIMEOUT_DEF;
  localparam int CORE_BUSY = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, abort, use_trig, trig, fault;
  logic [WW-1:0] ws, we, wst;
  logic [DW-1:0] ds, de, dst;
  logic [7:0]    reps;
  logic [15:0]   cool;
  logic          busy, done, err, pv;
  logic [7:0]    fcnt;

  glitch_sweep_if #(.WIDTH_W(WW), .DELAY_W(DW)) core_if ();

  glitch_sweep #(.WIDTH_W(WW), .DELAY_W(DW), .ACK_TIMEOUT(AT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .use_trig_i(use_trig), .trig_i(trig),
    .w_start_i(ws), .w_end_i(we), .w_step_i(wst),
    .d_start_i(ds), .d_end_i(de), .d_step_i(dst),
    .reps_i(reps), .cooldown_i(cool), .fault_i(fault),
    .core(core_if),
    .busy_o(busy), .done_o(done), .err_o(err),
    .point_valid_o(pv), .fault_cnt_o(fcnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Glitch core + target model: ready low CORE_BUSY cycles after each fire,
  // and for a faulty shot the target raises fault for 3 cycles once ready returns.
  int core_cnt = 0;
  bit core_dead = 1'b0;
  int flt_win = 0;
  int en_cnt = 0;
  bit shot_flt[$];
  bit flt_pat[$];

  assign core_if.glitch_ready = (core_cnt == 0);
  assign fault = (flt_win > 0);

  always @(posedge clk) begin
    if (flt_win > 0) flt_win <= flt_win - 1;
    if (core_if.glitch_en) begin
      en_cnt <= en_cnt + 1;
      if (!core_dead) core_cnt <= CORE_BUSY;
      if (flt_pat.size() > 0) shot_flt.push_back(flt_pat.pop_front());
      else shot_flt.push_back(1'($urandom_range(0, 1)));
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1 && shot_flt[$]) flt_win <= 3;
    end
  end

  int n_done = 0;
  int obs_w[$], obs_d[$], obs_f[$];

  always @(negedge clk) begin
    if (pv) begin
      obs_w.push_back(int'(core_if.width));
      obs_d.push_back(int'(core_if.delay));
      obs_f.push_back(int'(fcnt));
    end
    if (done) n_done <= n_done + 1;
  end

  task automatic set_cfg(input int a, b, c, d, e, f, r, cl);
    ws = WW'(a); we = WW'(b); wst = WW'(c);
    ds = DW'(d); de = DW'(e); dst = DW'(f);
    reps = 8'(r); cool = 16'(cl);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (core_if.glitch_en) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_sweep(input string tag, input int a, b, c, d, e, f, r, cl);
    int ew[$], ed[$];
    int w, dd, nx, re, s0, e0, d0, lat, ef;
    // Reference grid: delay inner, width outer, each axis stops when the next
    // value would pass its end, the top of its field, or the step is zero.
    w = a;
    while (1) begin
      dd = d;
      while (1) begin
        ew.push_back(w);
        ed.push_back(dd);
        nx = dd + f;
        if (f == 0 || nx > e || nx > 65535) break;
        dd = nx;
      end
      nx = w + c;
      if (c == 0 || nx > b || nx > 255) break;
      w = nx;
    end
    re = (r == 0) ? 1 : r;
    obs_w.delete(); obs_d.delete(); obs_f.delete();
    s0 = shot_flt.size();
    e0 = en_cnt;
    d0 = n_done;
    set_cfg(a, b, c, d, e, f, r, cl);
    pulse_start();
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 lat++;
      if (core_if.glitch_en) break;
    end
    chk({tag, "_en_lat"}, 32'(lat), 32'd2);
    wait_done({tag, "_done_seen"}, 20000);
    chk({tag, "_npts"}, 32'(obs_w.size()), 32'(ew.size()));
    for (int k = 0; k < ew.size() && k < obs_w.size(); k++) begin
      ef = 0;
      for (int j = 0; j < re; j++)
        if (s0 + k * re + j < shot_flt.size()) ef += int'(shot_flt[s0 + k * re + j]);
      if (ef > 255) ef = 255;
      chk($sformatf("%s_w%0d", tag, k), 32'(obs_w[k]), 32'(ew[k]));
      chk($sformatf("%s_d%0d", tag, k), 32'(obs_d[k]), 32'(ed[k]));
      chk($sformatf("%s_f%0d", tag, k), 32'(obs_f[k]), 32'(ef));
    end
    chk({tag, "_shots"}, 32'(en_cnt - e0), 32'(ew.size() * re));
    chk({tag, "_ndone"}, 32'(n_done - d0), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int e0, d0, p0, k;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; use_trig = 1'b0; trig = 1'b0;
    set_cfg(3, 9, 1, 40, 80, 5, 2, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({busy, done, err, pv, core_if.glitch_en}), 32'd0);
    chk("rst_data", {fcnt, core_if.width, core_if.delay}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_sweep("grid2x2", 10, 11, 1, 100, 200, 100, 1, 0);
    run_sweep("dtop", 5, 5, 1, 'hFFF0, 'hFFFF, 'h20, 1, 0);
    flt_pat = '{1'b1, 1'b0, 1'b1};
    run_sweep("reps3", 3, 3, 1, 7, 7, 1, 3, 4);
    chk("reps3_fcnt2", 32'((obs_f.size() > 0) ? obs_f[0] : -1), 32'd2);
    run_sweep("rev", 20, 10, 1, 500, 100, 7, 1, 0);

    for (int r = 0; r < 8; r++) begin
      int a, b, c, d, e, f;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      c = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(64, 255);
      d = $urandom_range(0, 65535);
      e = $urandom_range(0, 65535);
      f = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range('h4000, 'hFFFF);
      run_sweep($sformatf("rnd%0d", r), a, b, c, d, e, f,
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Trigger mode: only rising edges of the synchronised trigger fire.
    use_trig = 1'b1;
    set_cfg(1, 1, 1, 2, 2, 1, 3, 0);
    e0 = en_cnt;
    d0 = n_done;
    pulse_start();
    repeat (20) @(negedge clk);
    chk("trig_no_en_before_edge", 32'(en_cnt - e0), 32'd0);
    trig = 1'b1;
    repeat (50) @(negedge clk);
    chk("trig_level_one_shot", 32'(en_cnt - e0), 32'd1);
    trig = 1'b0;
    repeat (10) @(negedge clk);
    chk("trig_low_no_shot", 32'(en_cnt - e0), 32'd1);
    trig = 1'b1;
    repeat (2) @(negedge clk);
    trig = 1'b0;
    repeat (30) @(negedge clk);
    chk("trig_pulse_shot", 32'(en_cnt - e0), 32'd2);
    trig = 1'b1;
    repeat (2) @(negedge clk);
    trig = 1'b0;
    wait_done("trig_done_seen", 100);
    chk("trig_shots", 32'(en_cnt - e0), 32'd3);
    chk("trig_ndone", 32'(n_done - d0), 32'd1);
    use_trig = 1'b0;

    // Core never acknowledges: timeout error, then cleared by the next start.
    core_dead = 1'b1;
    set_cfg(0, 0, 1, 0, 0, 1, 1, 0);
    pulse_start();
    wait_en("to_en_seen");
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 k++;
      if (err) break;
    end
    chk("to_err_lat", 32'(k), 32'(AT));
    chk("to_done_with_err", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    chk("to_busy_low", 32'(busy), 32'd0);
    chk("to_err_sticky", 32'(err), 32'd1);
    core_dead = 1'b0;
    pulse_start();
    chk("to_err_cleared", 32'(err), 32'd0);
    wait_done("to_rerun_done", 200);

    // Abort while the core is still busy with the shot.
    set_cfg(0, 0, 1, 0, 0, 1, 1, 0);
    p0 = obs_w.size();
    pulse_start();
    wait_en("ab_en_seen");
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_done_next", 32'(done), 32'd1);
    abort = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_no_point", 32'(obs_w.size() - p0), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err", 32'(err), 32'd0);

    // Reset in the middle of a long cooldown.
    set_cfg(7, 7, 1, 9, 9, 1, 1, 20);
    pulse_start();
    wait_en("rs_en_seen");
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_width", 32'(core_if.width), 32'd7);
    d0 = n_done;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_ctrl", 32'({busy, done, err, pv, core_if.glitch_en}), 32'd0);
    chk("mid_rst_data", {fcnt, core_if.width, core_if.delay}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_no_done", 32'(n_done - d0), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
